rob_commit: RTL and testbench

- 64-entry reorder buffer: allocates ROB tags to up to 2 dispatched instructions per cycle and drives the register file's rename-tag write ports.
- Accepts up to 2 execution results per cycle.
- Retires up to 3 completed instructions per cycle in program order through the register file's three data write ports.
- Writer/producer side of the register file's rename-tag and data write interface.

---
 rtl/rob_commit_if.sv | 36 +++
 rtl/rob_commit.sv | 112 +++++++++++
 tb/tb_rob_commit.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// rob_commit_if: dispatch, rename-tag, writeback and commit signals of the reorder buffer
interface rob_commit_if #(
    parameter int LOC_W = 6,
    parameter int DATA_W = 16,
    parameter int REG_W = 3
);
    logic disp_valid0, disp_valid1, disp_has_dest0, disp_has_dest1, disp_ready;
    logic [REG_W-1:0] disp_dest0, disp_dest1;
    logic [LOC_W-1:0] disp_loc0, disp_loc1;
    logic [LOC_W-1:0] rob_locA, rob_locB, rob_locC, rob_locD;
    logic [REG_W-1:0] rob_waddrA, rob_waddrB, rob_waddrC, rob_waddrD;
    logic rob_wenA, rob_wenB, rob_wenC, rob_wenD;
    logic wb_valid0, wb_valid1;
    logic [LOC_W-1:0] wb_loc0, wb_loc1;
    logic [DATA_W-1:0] wb_data0, wb_data1;
    logic wen0, wen1, wen2;
    logic [REG_W-1:0] waddr0, waddr1, waddr2;
    logic [DATA_W-1:0] wdata0, wdata1, wdata2;
    logic [LOC_W:0] count;
    modport master (
        input disp_valid0, disp_valid1, disp_has_dest0, disp_has_dest1, disp_dest0, disp_dest1,
        input wb_valid0, wb_valid1, wb_loc0, wb_loc1, wb_data0, wb_data1,
        output disp_ready, disp_loc0, disp_loc1,
        output rob_locA, rob_locB, rob_locC, rob_locD, rob_waddrA, rob_waddrB, rob_waddrC, rob_waddrD,
        output rob_wenA, rob_wenB, rob_wenC, rob_wenD,
        output wen0, wen1, wen2, waddr0, waddr1, waddr2, wdata0, wdata1, wdata2, count
    );
    modport slave (
        output disp_valid0, disp_valid1, disp_has_dest0, disp_has_dest1, disp_dest0, disp_dest1,
        output wb_valid0, wb_valid1, wb_loc0, wb_loc1, wb_data0, wb_data1,
        input disp_ready, disp_loc0, disp_loc1,
        input rob_locA, rob_locB, rob_locC, rob_locD, rob_waddrA, rob_waddrB, rob_waddrC, rob_waddrD,
        input rob_wenA, rob_wenB, rob_wenC, rob_wenD,
        input wen0, wen1, wen2, waddr0, waddr1, waddr2, wdata0, wdata1, wdata2, count
    );
endinterface

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with 2-wide dispatch/writeback and 3-wide in-order commit
module rob_commit #(
    parameter int DEPTH = 64,
    parameter int LOC_W = 6,
    parameter int DATA_W = 16,
    parameter int REG_W = 3
) (
    input logic clk,
    input logic reset,
    rob_commit_if.master bus
);
    localparam int CW = LOC_W + 1;
    logic [LOC_W-1:0] head_q, tail_q;
    logic [CW-1:0] count_q;
    logic [DEPTH-1:0] valid_q, done_q, has_dest_q;
    logic [REG_W-1:0] dest_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [2:0] wen_q;
    logic [REG_W-1:0] waddr_q [3];
    logic [DATA_W-1:0] wdata_q [3];
    logic acc0, acc1;
    logic [1:0] ndisp, n;
    logic [LOC_W-1:0] loc [3];
    logic [2:0] cm;

    assign bus.disp_ready = count_q <= CW'(DEPTH - 2);
    assign bus.disp_loc0 = tail_q;
    assign bus.disp_loc1 = tail_q + LOC_W'(1);
    assign bus.rob_wenB = acc0 & bus.disp_has_dest0;
    assign bus.rob_locB = bus.disp_loc0;
    assign bus.rob_waddrB = bus.disp_dest0;
    assign bus.rob_wenA = acc1 & bus.disp_has_dest1;
    assign bus.rob_locA = bus.disp_loc1;
    assign bus.rob_waddrA = bus.disp_dest1;
    assign bus.rob_wenC = 1'b0;
    assign bus.rob_wenD = 1'b0;
    assign bus.rob_locC = '0;
    assign bus.rob_locD = '0;
    assign bus.rob_waddrC = '0;
    assign bus.rob_waddrD = '0;
    assign bus.wen0 = wen_q[0];
    assign bus.wen1 = wen_q[1];
    assign bus.wen2 = wen_q[2];
    assign bus.waddr0 = waddr_q[0];
    assign bus.waddr1 = waddr_q[1];
    assign bus.waddr2 = waddr_q[2];
    assign bus.wdata0 = wdata_q[0];
    assign bus.wdata1 = wdata_q[1];
    assign bus.wdata2 = wdata_q[2];
    assign bus.count = count_q;

    // Accept dispatch slots and find the leading run of finished entries at head
    always_comb begin
        acc0 = bus.disp_valid0 & bus.disp_ready;
        acc1 = acc0 & bus.disp_valid1;
        ndisp = {1'b0, acc0} + {1'b0, acc1};
        for (int k = 0; k < 3; k++) loc[k] = head_q + LOC_W'(k);
        cm[0] = valid_q[loc[0]] & done_q[loc[0]] & (count_q != '0);
        cm[1] = cm[0] & valid_q[loc[1]] & done_q[loc[1]] & (count_q >= CW'(2));
        cm[2] = cm[1] & valid_q[loc[2]] & done_q[loc[2]] & (count_q >= CW'(3));
        n = cm[2] ? 2'd3 : cm[1] ? 2'd2 : {1'b0, cm[0]};
    end

    // Pointers, entry state and registered commit lanes; commit clears after writeback, dispatch last
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q <= '0;
            wen_q <= '0;
            for (int k = 0; k < 3; k++) begin
                waddr_q[k] <= '0;
                wdata_q[k] <= '0;
            end
        end else begin
            head_q <= head_q + LOC_W'(n);
            tail_q <= tail_q + LOC_W'(ndisp);
            count_q <= count_q + CW'(ndisp) - CW'(n);
            if (bus.wb_valid0 && valid_q[bus.wb_loc0]) begin
                done_q[bus.wb_loc0] <= 1'b1;
                data_q[bus.wb_loc0] <= bus.wb_data0;
            end
            if (bus.wb_valid1 && valid_q[bus.wb_loc1]) begin
                done_q[bus.wb_loc1] <= 1'b1;
                data_q[bus.wb_loc1] <= bus.wb_data1;
            end
            for (int k = 0; k < 3; k++) begin
                if (cm[k]) begin
                    valid_q[loc[k]] <= 1'b0;
                    done_q[loc[k]] <= 1'b0;
                end
                wen_q[k] <= cm[k] & has_dest_q[loc[k]];
                waddr_q[k] <= cm[k] ? dest_q[loc[k]] : '0;
                wdata_q[k] <= cm[k] ? data_q[loc[k]] : '0;
            end
            if (acc0) begin
                valid_q[bus.disp_loc0] <= 1'b1;
                done_q[bus.disp_loc0] <= 1'b0;
                has_dest_q[bus.disp_loc0] <= bus.disp_has_dest0;
                dest_q[bus.disp_loc0] <= bus.disp_dest0;
            end
            if (acc1) begin
                valid_q[bus.disp_loc1] <= 1'b1;
                done_q[bus.disp_loc1] <= 1'b0;
                has_dest_q[bus.disp_loc1] <= bus.disp_has_dest1;
                dest_q[bus.disp_loc1] <= bus.disp_dest1;
            end
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed checks of dispatch, rename, writeback, commit, full, wrap and reset
module tb_rob_commit;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    int seq_exp = 0;

    always #5 clk = ~clk;

    rob_commit_if bus ();
    rob_commit dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic v0, input logic [2:0] d0, input logic h0,
                        input logic v1, input logic [2:0] d1, input logic h1);
        bus.disp_valid0 = v0;
        bus.disp_dest0 = d0;
        bus.disp_has_dest0 = h0;
        bus.disp_valid1 = v1;
        bus.disp_dest1 = d1;
        bus.disp_has_dest1 = h1;
    endtask

    task automatic wb(input logic v0, input logic [5:0] l0, input logic [15:0] x0,
                      input logic v1, input logic [5:0] l1, input logic [15:0] x1);
        bus.wb_valid0 = v0;
        bus.wb_loc0 = l0;
        bus.wb_data0 = x0;
        bus.wb_valid1 = v1;
        bus.wb_loc1 = l1;
        bus.wb_data1 = x1;
    endtask

    task automatic idle;
        disp(0, 0, 0, 0, 0, 0);
        wb(0, 0, 0, 0, 0, 0);
    endtask

    task automatic lane(input logic w, input logic [2:0] a, input logic [15:0] d);
        if (w) begin
            chk("wrap_addr", 32'(a), 32'(seq_exp % 8));
            chk("wrap_data", 32'(d), 32'(seq_exp));
            seq_exp++;
        end
    endtask

    task automatic mon;
        lane(bus.wen0, bus.waddr0, bus.wdata0);
        lane(bus.wen1, bus.waddr1, bus.wdata1);
        lane(bus.wen2, bus.waddr2, bus.wdata2);
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (2) step();
        reset = 1'b0;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_wen", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 0);
        chk("rst_ready", 32'(bus.disp_ready), 1);

        disp(1, 3, 1, 1, 3, 1);
        #1;
        chk("loc0", 32'(bus.disp_loc0), 0);
        chk("loc1", 32'(bus.disp_loc1), 1);
        chk("wenB_locB", {bus.rob_wenB, 25'd0, bus.rob_locB}, {1'b1, 31'd0});
        chk("wenA_locA", {bus.rob_wenA, 25'd0, bus.rob_locA}, {1'b1, 31'd1});
        chk("waddrA", 32'(bus.rob_waddrA), 3);
        step();
        idle();
        chk("count2", 32'(bus.count), 2);

        wb(1, 1, 16'hBEEF, 0, 0, 0);
        step();
        idle();
        step();
        chk("no_early", 32'(bus.wen0), 0);
        chk("count_hold", 32'(bus.count), 2);
        wb(1, 0, 16'h1234, 0, 0, 0);
        step();
        idle();
        chk("latency", 32'(bus.wen0), 0);
        step();
        chk("c_wen", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 3);
        chk("c_lane0", {bus.waddr0, bus.wdata0}, {3'd3, 16'h1234});
        chk("c_lane1", {bus.waddr1, bus.wdata1}, {3'd3, 16'hBEEF});
        chk("c_count", 32'(bus.count), 0);
        step();
        chk("c_once", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 0);

        disp(1, 1, 1, 1, 2, 0);
        step();
        disp(1, 3, 1, 1, 4, 1);
        step();
        disp(1, 5, 1, 0, 0, 0);
        step();
        idle();
        chk("five_count", 32'(bus.count), 5);
        wb(1, 6, 16'h000E, 1, 5, 16'h000D);
        step();
        wb(1, 4, 16'h000C, 1, 3, 16'h000B);
        step();
        wb(1, 2, 16'h000A, 0, 0, 0);
        step();
        idle();
        step();
        chk("three_wen", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 5);
        chk("three_l0", {bus.waddr0, bus.wdata0}, {3'd1, 16'h000A});
        chk("three_l2", {bus.waddr2, bus.wdata2}, {3'd3, 16'h000C});
        chk("three_count", 32'(bus.count), 2);
        step();
        chk("two_wen", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 3);
        chk("two_l0", {bus.waddr0, bus.wdata0}, {3'd4, 16'h000D});
        chk("two_l1", {bus.waddr1, bus.wdata1}, {3'd5, 16'h000E});
        chk("two_count", 32'(bus.count), 0);

        seq_exp = 0;
        for (int i = 0; i < 32; i++) begin
            disp(1, 3'(2 * i), 1, 1, 3'(2 * i + 1), 1);
            if (i > 0) wb(1, 6'(7 + 2 * i - 2), 16'(2 * i - 2), 1, 6'(7 + 2 * i - 1), 16'(2 * i - 1));
            else wb(0, 0, 0, 0, 0, 0);
            step();
            mon();
        end
        idle();
        wb(1, 6'(7 + 62), 16'd62, 1, 6'(7 + 63), 16'd63);
        step();
        mon();
        idle();
        repeat (6) begin
            step();
            mon();
        end
        chk("wrap_all", 32'(seq_exp), 64);
        chk("wrap_count", 32'(bus.count), 0);

        for (int i = 0; i < 32; i++) begin
            chk("fill_ready", 32'(bus.disp_ready), 1);
            disp(1, 1, 1, 1, 2, 1);
            step();
        end
        idle();
        chk("full_count", 32'(bus.count), 64);
        chk("full_ready", 32'(bus.disp_ready), 0);
        disp(1, 3, 1, 0, 0, 0);
        #1;
        chk("full_wenB", 32'(bus.rob_wenB), 0);
        step();
        idle();
        chk("full_hold", 32'(bus.count), 64);
        chk("full_tail", 32'(bus.disp_loc0), 7);

        wb(1, 7, 16'h0777, 1, 8, 16'h0888);
        step();
        idle();
        step();
        chk("pre_rst_wen", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 3);
        chk("pre_rst_data", {bus.wdata1, bus.wdata0}, {16'h0888, 16'h0777});
        chk("pre_rst_count", 32'(bus.count), 62);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_wen", {29'd0, bus.wen2, bus.wen1, bus.wen0}, 0);
        chk("mid_rst_lanes", {bus.waddr0, bus.wdata0, bus.waddr1}, 0);
        disp(1, 5, 1, 0, 0, 0);
        #1;
        chk("post_rst_loc", 32'(bus.disp_loc0), 0);
        chk("post_rst_wenB", {bus.rob_wenB, 25'd0, bus.rob_locB}, {1'b1, 31'd0});
        step();
        idle();
        chk("post_rst_count", 32'(bus.count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
